// File: rtl/multi_timer_core_pkg.sv
// Shared definitions for the multi-channel MM:SS BCD timer: state codes,
// digit widths and packing offsets, plus two-digit BCD step helpers.
package multi_timer_core_pkg;

  localparam int DIGIT_W = 4;
  localparam int PAIR_W  = 2 * DIGIT_W;
  localparam int CH_W    = 4 * DIGIT_W;
  localparam int SEC_OFS = 0;
  localparam int MIN_OFS = PAIR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } tmr_state_e;

  // Callers guarantee the result stays within the valid range (no 99->00 here).
  function automatic logic [PAIR_W-1:0] bcd_inc(input logic [PAIR_W-1:0] v);
    if (v[DIGIT_W-1:0] == 4'd9) return {v[PAIR_W-1:DIGIT_W] + 4'd1, 4'd0};
    return {v[PAIR_W-1:DIGIT_W], v[DIGIT_W-1:0] + 4'd1};
  endfunction

  function automatic logic [PAIR_W-1:0] bcd_dec(input logic [PAIR_W-1:0] v);
    if (v[DIGIT_W-1:0] == 4'd0) return {v[PAIR_W-1:DIGIT_W] - 4'd1, 4'd9};
    return {v[PAIR_W-1:DIGIT_W], v[DIGIT_W-1:0] - 4'd1};
  endfunction

endpackage

// File: rtl/multi_timer_core_channel.sv
// One timer channel: IDLE/RUN/PAUSE/DONE FSM, MM:SS BCD up/down counter,
// edit logic and a one-cycle finish pulse on entry to DONE.
module multi_timer_core_channel
  import multi_timer_core_pkg::*;
#(
  parameter int MAX_MIN = 99
) (
  input  logic            CLK_50MHZ,
  input  logic            reset,
  input  logic            tick,
  input  logic            start,
  input  logic            stop,
  input  logic            clear,
  input  logic            inc_sec,
  input  logic            inc_min,
  input  logic            count_up,
  output logic [CH_W-1:0] digits,
  output logic [1:0]      state,
  output logic            finish
);

  localparam logic [PAIR_W-1:0] MAX_BCD = {DIGIT_W'(MAX_MIN / 10), DIGIT_W'(MAX_MIN % 10)};
  localparam logic [PAIR_W-1:0] SEC_MAX = 8'h59;

  tmr_state_e        state_q, state_d;
  logic              mode_q, mode_d;
  logic [PAIR_W-1:0] min_q, min_d, sec_q, sec_d;
  logic              finish_q;
  logic              editable, is_zero;

  assign editable = (state_q == ST_IDLE) || (state_q == ST_PAUSE);
  assign is_zero  = (min_q == '0) && (sec_q == '0);

  always_ff @(posedge CLK_50MHZ) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= 1'b0;
      min_q    <= '0;
      sec_q    <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      finish_q <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  // Commands are single-cycle pulses with no back-pressure. The highest-priority
  // pulse that applies in the current state acts; inapplicable ones are dropped.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (clear) begin
      state_d = ST_IDLE;
      min_d   = '0;
      sec_d   = '0;
    end else if (stop && state_q == ST_RUN) begin
      state_d = ST_PAUSE;
    end else if (start && editable && (count_up || !is_zero)) begin
      state_d = ST_RUN;
      mode_d  = count_up;
    end else if (inc_min && editable) begin
      min_d = (min_q == MAX_BCD) ? '0 : bcd_inc(min_q);
    end else if (inc_sec && editable) begin
      sec_d = (sec_q == SEC_MAX) ? '0 : bcd_inc(sec_q);
    end else if (tick && state_q == ST_RUN) begin
      if (mode_q) begin
        if (!(min_q == MAX_BCD && sec_q == SEC_MAX)) begin
          if (sec_q == SEC_MAX) begin
            min_d = bcd_inc(min_q);
            sec_d = '0;
          end else begin
            sec_d = bcd_inc(sec_q);
          end
        end
        if (min_d == MAX_BCD && sec_d == SEC_MAX) state_d = ST_DONE;
      end else begin
        if (!is_zero) begin
          if (sec_q == '0) begin
            min_d = bcd_dec(min_q);
            sec_d = SEC_MAX;
          end else begin
            sec_d = bcd_dec(sec_q);
          end
        end
        if (min_d == '0 && sec_d == '0) state_d = ST_DONE;
      end
    end
  end

  always_comb begin
    digits                    = '0;
    digits[MIN_OFS +: PAIR_W] = min_q;
    digits[SEC_OFS +: PAIR_W] = sec_q;
    state                     = state_q;
    finish                    = finish_q;
  end

endmodule

// File: rtl/multi_timer_core.sv
// N-channel MM:SS timer core: shared prescaler tick, per-channel timers,
// digit/state packing (ch0 in the low bits) and the any_done summary.
module multi_timer_core
  import multi_timer_core_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int MAX_MIN = 99
) (
  input  logic                 CLK_50MHZ,
  input  logic                 reset,
  input  logic [N_CH-1:0]      start,
  input  logic [N_CH-1:0]      stop,
  input  logic [N_CH-1:0]      clear,
  input  logic [N_CH-1:0]      inc_sec,
  input  logic [N_CH-1:0]      inc_min,
  input  logic [N_CH-1:0]      count_up,
  output logic [16*N_CH-1:0]   digits,
  output logic [2*N_CH-1:0]    state,
  output logic [N_CH-1:0]      finish,
  output logic                 any_done
);

  localparam int TC = CLK_HZ / TICK_HZ - 1;
  localparam int PW = (TC > 0) ? $clog2(TC + 1) : 1;

  logic [PW-1:0]   presc_q;
  logic            tick;
  logic [N_CH-1:0] done_vec;

  assign tick = (presc_q == PW'(TC));

  // Free-running; only reset realigns it, so channels share one tick phase.
  always_ff @(posedge CLK_50MHZ) begin
    if (!reset)    presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + PW'(1);
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    multi_timer_core_channel #(.MAX_MIN(MAX_MIN)) u_ch (
      .CLK_50MHZ (CLK_50MHZ),
      .reset     (reset),
      .tick      (tick),
      .start     (start[g]),
      .stop      (stop[g]),
      .clear     (clear[g]),
      .inc_sec   (inc_sec[g]),
      .inc_min   (inc_min[g]),
      .count_up  (count_up[g]),
      .digits    (digits[CH_W*g +: CH_W]),
      .state     (state[2*g +: 2]),
      .finish    (finish[g])
    );
    assign done_vec[g] = (state[2*g +: 2] == ST_DONE);
  end

  assign any_done = |done_vec;

endmodule
